sfr_arb: RTL

SFR_ARB -- requirements
Module: sfr_arb

---
 rtl/sfr_arb_pkg.sv | 14 +
 rtl/sfr_arb_pick.sv | 21 ++
 rtl/sfr_arb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sfr_arb_pkg.sv
// Shared types and constants for the two-master SFR bus arbiter.
package sfr_arb_pkg;

    localparam int SFR_AW      = 8;
    localparam int SFR_DW      = 16;
    localparam int LOCK_TO_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/sfr_arb_pick.sv
// Two-way round-robin pick among eligible requesters.
module sfr_arb_pick (
    input  logic [1:0] req,
    input  logic [1:0] elig,
    input  logic       last_m1,
    output logic [1:0] gnt
);

    logic [1:0] cand;

    assign cand = req & elig;

    always_comb begin
        gnt = cand;
        // On a tie the master that did not win last time goes first.
        if (cand == 2'b11) begin
            gnt = last_m1 ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sfr_arb.sv
// Arbiter sharing one SFR bank between two masters, with optional
// exclusive locking and an idle timeout that releases a stale lock.
module sfr_arb
    import sfr_arb_pkg::*;
#(
    parameter int LOCK_TO = LOCK_TO_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [SFR_AW-1:0] m0_addr,
    input  logic              m0_r,
    input  logic [1:0]        m0_w,
    input  logic [SFR_DW-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [SFR_DW-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [SFR_AW-1:0] m1_addr,
    input  logic              m1_r,
    input  logic [1:0]        m1_w,
    input  logic [SFR_DW-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [SFR_DW-1:0] m1_rdata,
    output logic              sfr_sel,
    output logic [SFR_AW-1:0] sfr_addr,
    output logic              sfr_r,
    output logic [1:0]        sfr_w,
    output logic [SFR_DW-1:0] sfr_dwrite,
    input  logic [SFR_DW-1:0] sfr_data,
    output logic              busy,
    output logic [1:0]        lock_own
);

    localparam int CW = $clog2(LOCK_TO + 1);

    state_t            state_q, state_d;
    logic [SFR_AW-1:0] addr_q, addr_d;
    logic              r_q, r_d;
    logic [1:0]        w_q, w_d;
    logic [SFR_DW-1:0] wdata_q, wdata_d;
    logic              lock_q, lock_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic [SFR_DW-1:0] rdata0_q, rdata0_d;
    logic [SFR_DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]        lock_own_q, lock_own_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [1:0] req;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic [1:0] win_oh;

    assign req    = {m1_req, m0_req};
    assign elig   = (lock_own_q == 2'b00) ? 2'b11 : lock_own_q;
    assign win_oh = win_q ? 2'b10 : 2'b01;

    sfr_arb_pick u_pick (
        .req     (req),
        .elig    (elig),
        .last_m1 (last_q),
        .gnt     (gnt)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        r_d        = r_q;
        w_d        = w_q;
        wdata_d    = wdata_q;
        lock_d     = lock_q;
        win_d      = win_q;
        last_d     = last_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        lock_own_d = lock_own_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    addr_d  = gnt[1] ? m1_addr : m0_addr;
                    r_d     = gnt[1] ? m1_r : m0_r;
                    w_d     = gnt[1] ? m1_w : m0_w;
                    wdata_d = gnt[1] ? m1_wdata : m0_wdata;
                    lock_d  = gnt[1] ? m1_lock : m0_lock;
                    win_d   = gnt[1];
                    last_d  = gnt[1];
                    state_d = XFER;
                end
                // Under a lock only the owner can be granted.
                if (lock_own_q == 2'b00 || gnt != 2'b00) begin
                    cnt_d = '0;
                end else if ((lock_own_q & req) == 2'b00) begin
                    if (cnt_q == CW'(LOCK_TO - 1)) begin
                        cnt_d      = '0;
                        lock_own_d = 2'b00;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            XFER: begin
                state_d = ACK;
                if (win_q) begin
                    rdata1_d = sfr_data;
                end else begin
                    rdata0_d = sfr_data;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (lock_q) begin
                    lock_own_d = win_oh;
                end else if (lock_own_q == win_oh) begin
                    lock_own_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            r_q        <= 1'b0;
            w_q        <= 2'b00;
            wdata_q    <= '0;
            lock_q     <= 1'b0;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            lock_own_q <= 2'b00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            r_q        <= r_d;
            w_q        <= w_d;
            wdata_q    <= wdata_d;
            lock_q     <= lock_d;
            win_q      <= win_d;
            last_q     <= last_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            lock_own_q <= lock_own_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sfr_sel    = (state_q == XFER);
    assign sfr_addr   = sfr_sel ? addr_q : '0;
    assign sfr_r      = sfr_sel & r_q;
    assign sfr_w      = sfr_sel ? w_q : 2'b00;
    assign sfr_dwrite = sfr_sel ? wdata_q : '0;
    assign m0_ack     = (state_q == ACK) & ~win_q;
    assign m1_ack     = (state_q == ACK) & win_q;
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;
    assign busy       = (state_q != IDLE);
    assign lock_own   = lock_own_q;

endmodule
